// File: rtl/alu_result_collector.sv
// Collects one-hot tagged ALU unit results into a small FIFO and hands them to a
// valid/ready consumer with sticky error flags. Optional macro: ALU_COLLECT_SEQ_EN.
module alu_result_collector #(
  parameter int Width = 16,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [2*Width-1:0]       Arith_OUT,
  input  logic [Width-1:0]         Logic_OUT,
  input  logic [Width-1:0]         Shift_OUT,
  input  logic [Width-1:0]         CMP_OUT,
  input  logic                     Arith_Flag,
  input  logic                     Logic_Flag,
  input  logic                     Shift_Flag,
  input  logic                     CMP_Flag,
  input  logic                     RES_READY,
  input  logic                     ERR_CLR,
  output logic [2*Width-1:0]       RES_DATA,
  output logic [1:0]               RES_SRC,
  output logic                     RES_VALID,
  output logic [$clog2(DEPTH):0]   FIFO_CNT,
  output logic                     OVF_ERR,
`ifdef ALU_COLLECT_SEQ_EN
  output logic [7:0]               RES_SEQ,
`endif
  output logic                     MULTI_ERR
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 2 * Width;
`ifdef ALU_COLLECT_SEQ_EN
  localparam int EW = DW + 2 + 8;
`else
  localparam int EW = DW + 2;
`endif

  // Flag vector indexed by the source code so the one-hot position is the tag.
  logic [3:0]    flags;
  logic          one_hot;
  logic          multi_hit;
  logic [1:0]    wr_src;
  logic [DW-1:0] wr_data;
  logic [EW-1:0] wr_entry;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] last_q, last_d;
  logic          ovf_q, ovf_d;
  logic          multi_q, multi_d;
  logic [EW-1:0] head_entry;

  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;

  assign flags     = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
  assign one_hot   = (flags != 4'd0) && ((flags & 4'(flags - 4'd1)) == 4'd0);
  assign multi_hit = (flags != 4'd0) && !one_hot;

  always_comb begin
    wr_src  = 2'd0;
    wr_data = '0;
    case (flags)
      4'b0001: begin wr_src = 2'd0; wr_data = Arith_OUT; end
      4'b0010: begin wr_src = 2'd1; wr_data = {{Width{1'b0}}, Logic_OUT}; end
      4'b0100: begin wr_src = 2'd2; wr_data = {{Width{1'b0}}, CMP_OUT}; end
      4'b1000: begin wr_src = 2'd3; wr_data = {{Width{1'b0}}, Shift_OUT}; end
      default: begin wr_src = 2'd0; wr_data = '0; end
    endcase
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign pop   = !empty && RES_READY;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = one_hot && (!full || pop);
  assign drop  = one_hot && full && !pop;

`ifdef ALU_COLLECT_SEQ_EN
  logic [7:0] seq_q, seq_d;

  assign wr_entry = {seq_q, wr_src, wr_data};
  assign seq_d    = push ? 8'(seq_q + 8'd1) : seq_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      seq_q <= 8'd0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign RES_SEQ = head_entry[EW-1 -: 8];
`else
  assign wr_entry = {wr_src, wr_data};
`endif

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A new error event outranks a clear in the same cycle.
    ovf_d   = drop      | (ovf_q   & ~ERR_CLR);
    multi_d = multi_hit | (multi_q & ~ERR_CLR);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      multi_q  <= multi_d;
    end
  end

  // Empty FIFO shows the last popped entry (zero after reset).
  assign head_entry = empty ? last_q : mem_q[rd_ptr_q];

  assign RES_DATA  = head_entry[DW-1:0];
  assign RES_SRC   = head_entry[DW+1:DW];
  assign RES_VALID = !empty;
  assign FIFO_CNT  = cnt_q;
  assign OVF_ERR   = ovf_q;
  assign MULTI_ERR = multi_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: expected entries queued at drive time,
// compared when the DUT pops them.
module tb_alu_result_collector;
  localparam int W = 16;
  localparam int D = 4;

  logic          CLK;
  logic          RST;
  logic [2*W-1:0] Arith_OUT;
  logic [W-1:0]  Logic_OUT, Shift_OUT, CMP_OUT;
  logic          Arith_Flag, Logic_Flag, Shift_Flag, CMP_Flag;
  logic          RES_READY, ERR_CLR;
  logic [2*W-1:0] RES_DATA;
  logic [1:0]    RES_SRC;
  logic          RES_VALID;
  logic [2:0]    FIFO_CNT;
  logic          OVF_ERR, MULTI_ERR;
`ifdef ALU_COLLECT_SEQ_EN
  logic [7:0]    RES_SEQ;
`endif

  alu_result_collector #(.Width(W), .DEPTH(D)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .Shift_OUT(Shift_OUT), .CMP_OUT(CMP_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .Shift_Flag(Shift_Flag), .CMP_Flag(CMP_Flag),
    .RES_READY(RES_READY), .ERR_CLR(ERR_CLR),
    .RES_DATA(RES_DATA), .RES_SRC(RES_SRC), .RES_VALID(RES_VALID), .FIFO_CNT(FIFO_CNT),
    .OVF_ERR(OVF_ERR),
`ifdef ALU_COLLECT_SEQ_EN
    .RES_SEQ(RES_SEQ),
`endif
    .MULTI_ERR(MULTI_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
    logic [7:0]  seq;
  } ent_t;

  ent_t       exp_q[$];
  ent_t       last_e;
  logic       m_ovf, m_multi;
  logic [7:0] m_seq;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_e.data = '0;
    last_e.src  = '0;
    last_e.seq  = '0;
    m_ovf   = 1'b0;
    m_multi = 1'b0;
    m_seq   = 8'd0;
  endtask

  task automatic post_check(input string tag);
    ent_t h;
    h = (exp_q.size() != 0) ? exp_q[0] : last_e;
    check_eq({tag, "_cnt"},   FIFO_CNT, exp_q.size());
    check_eq({tag, "_valid"}, RES_VALID, exp_q.size() != 0);
    check_eq({tag, "_ovf"},   OVF_ERR, m_ovf);
    check_eq({tag, "_multi"}, MULTI_ERR, m_multi);
    check_eq({tag, "_data"},  RES_DATA, h.data);
    check_eq({tag, "_src"},   RES_SRC, h.src);
`ifdef ALU_COLLECT_SEQ_EN
    check_eq({tag, "_seq"},   RES_SEQ, h.seq);
`endif
  endtask

  // One clock of stimulus; fl bit order: arith, logic, cmp, shift (matches source code).
  task automatic cycle(input string tag, input logic [3:0] fl, input logic [31:0] a,
                       input logic [15:0] l, input logic [15:0] c, input logic [15:0] s,
                       input logic rdy, input logic clr);
    ent_t e;
    logic pop, full, drop, multi;
    @(negedge CLK);
    Arith_Flag = fl[0]; Logic_Flag = fl[1]; CMP_Flag = fl[2]; Shift_Flag = fl[3];
    Arith_OUT = a; Logic_OUT = l; CMP_OUT = c; Shift_OUT = s;
    RES_READY = rdy; ERR_CLR = clr;
    #2;
    pop  = (exp_q.size() != 0) && rdy;
    full = (exp_q.size() == D);
    drop = 1'b0;
    multi = ($countones(fl) > 1);
    if (pop) begin
      check_eq({tag, "_pop_data"}, RES_DATA, exp_q[0].data);
      check_eq({tag, "_pop_src"},  RES_SRC,  exp_q[0].src);
`ifdef ALU_COLLECT_SEQ_EN
      check_eq({tag, "_pop_seq"},  RES_SEQ,  exp_q[0].seq);
`endif
      last_e = exp_q.pop_front();
      $display("pop  %s src=%0d data=%08h seq=%0d", tag, last_e.src, last_e.data, last_e.seq);
    end
    if ($countones(fl) == 1) begin
      case (fl)
        4'b0001: begin e.data = a;           e.src = 2'd0; end
        4'b0010: begin e.data = {16'h0, l};  e.src = 2'd1; end
        4'b0100: begin e.data = {16'h0, c};  e.src = 2'd2; end
        default: begin e.data = {16'h0, s};  e.src = 2'd3; end
      endcase
      if (!full || pop) begin
        e.seq = m_seq;
        m_seq = m_seq + 8'd1;
        exp_q.push_back(e);
        $display("push %s src=%0d data=%08h", tag, e.src, e.data);
      end else begin
        drop = 1'b1;
        $display("drop %s src=%0d data=%08h", tag, e.src, e.data);
      end
    end
    m_ovf   = drop  | (m_ovf   & ~clr);
    m_multi = multi | (m_multi & ~clr);
    @(posedge CLK);
    #1;
    post_check(tag);
  endtask

  task automatic idle(input string tag, input logic rdy, input logic clr);
    cycle(tag, 4'b0000, 32'h0, 16'h0, 16'h0, 16'h0, rdy, clr);
  endtask

  initial begin
    RST = 1'b0;
    Arith_OUT = '0; Logic_OUT = '0; Shift_OUT = '0; CMP_OUT = '0;
    Arith_Flag = 0; Logic_Flag = 0; Shift_Flag = 0; CMP_Flag = 0;
    RES_READY = 0; ERR_CLR = 0;
    model_reset();
    #12;
    post_check("reset");
    @(negedge CLK);
    RST = 1'b1;

    // Single logic result, consumer stalled.
    cycle("logic", 4'b0010, 32'h0, 16'hA5A5, 16'h0, 16'h0, 1'b0, 1'b0);
    idle("hold", 1'b0, 1'b0);
    idle("drain1", 1'b1, 1'b0);

    // Arithmetic result with consumer ready, then drained.
    cycle("arith", 4'b0001, 32'hFFFF0001, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle("arith_pop", 1'b1, 1'b0);
    idle("empty_hold", 1'b1, 1'b0);

    // Overflow: five CMP pushes into four entries.
    for (int i = 1; i <= 5; i++)
      cycle("cmp_fill", 4'b0100, 32'h0, 16'h0, 16'(i), 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle("cmp_drain", 1'b1, 1'b0);
    idle("ovf_clr", 1'b0, 1'b1);

    // Full with simultaneous push and pop: no drop.
    for (int i = 1; i <= 4; i++)
      cycle("fill", 4'b0010, 32'h0, 16'(16'h10 + i), 16'h0, 16'h0, 1'b0, 1'b0);
    cycle("full_pp", 4'b1000, 32'h0, 16'h0, 16'h0, 16'h0008, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle("pp_drain", 1'b1, 1'b0);

    // Multi-flag error, clear, and clear colliding with a new error.
    cycle("multi", 4'b1010, 32'h0, 16'h1111, 16'h0, 16'h2222, 1'b0, 1'b0);
    idle("multi_clr", 1'b0, 1'b1);
    cycle("multi_again", 4'b0101, 32'h5, 16'h0, 16'h6, 16'h0, 1'b0, 1'b0);
    cycle("clr_vs_err", 4'b1111, 32'h5, 16'h1, 16'h6, 16'h2, 1'b0, 1'b1);
    idle("multi_clr2", 1'b0, 1'b1);

    // Mixed random traffic, including wrap of pointers and the sequence tag.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] fl;
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      fl = 4'b0001 << $urandom_range(0, 3);
      else if (r < 8) fl = 4'b0000;
      else            fl = 4'($urandom_range(0, 15));
      cycle("rand", fl, $urandom, 16'($urandom), 16'($urandom), 16'($urandom),
            (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset with entries buffered.
    idle("pre_rst_clr", 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle("pre_rst_drain", 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++)
      cycle("pre_rst", 4'b0100, 32'h0, 16'h0, 16'(16'h70 + i), 16'h0, 1'b0, 1'b0);
    @(negedge CLK);
    RES_READY = 1'b0; ERR_CLR = 1'b0;
    Arith_Flag = 0; Logic_Flag = 0; Shift_Flag = 0; CMP_Flag = 0;
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    post_check("async_rst");
    #1;
    RST = 1'b1;
    cycle("post_rst", 4'b0010, 32'h0, 16'h0BEE, 16'h0, 16'h0, 1'b0, 1'b0);
    idle("post_rst_pop", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream stage of the 16-bit ALU top level.
- Samples the four registered unit outputs (arithmetic, logic, shift, compare) and their one-cycle valid flags every clock.
- Tags each result with its source unit and buffers it in a small FIFO.
- Presents results to the consumer over a valid/ready handshake, with sticky error reporting.

Parameters:
- Width, 16, operand width of the ALU; narrow results are Width bits, arithmetic results are 2*Width bits.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active low.
- Arith_OUT  input  2*Width  arithmetic unit result.
- Logic_OUT  input  Width  logic unit result.
- Shift_OUT  input  Width  shift unit result.
- CMP_OUT  input  Width  compare unit result.
- Arith_Flag  input  1  Arith_OUT valid this cycle.
- Logic_Flag  input  1  Logic_OUT valid this cycle.
- Shift_Flag  input  1  Shift_OUT valid this cycle.
- CMP_Flag  input  1  CMP_OUT valid this cycle.
- RES_READY  input  1  consumer accepts the head entry.
- ERR_CLR  input  1  synchronous clear of the sticky errors.
- RES_DATA  output  2*Width  head entry data.
- RES_SRC  output  2  head entry source: 00 arith, 01 logic, 10 cmp, 11 shift.
- RES_VALID  output  1  FIFO not empty.
- FIFO_CNT  output  clog2(DEPTH)+1  current occupancy.
- OVF_ERR  output  1  sticky: a result was dropped because the FIFO was full.
- MULTI_ERR  output  1  sticky: more than one flag was high in one cycle.

Behaviour:
- Reset (RST=0, asynchronous): FIFO empty, read/write pointers 0, FIFO_CNT=0, RES_VALID=0, RES_DATA=0, RES_SRC=0, OVF_ERR=0, MULTI_ERR=0.
- Capture, once per rising edge:
  - Exactly one flag high: push {src, data}.
  - Narrow results (Logic_OUT, Shift_OUT, CMP_OUT) are zero-extended to 2*Width.
  - Arith_OUT is stored unmodified.
- Zero flags high: no push.
- Two or more flags high: no push, MULTI_ERR set to 1.
- Latency: a flag high before edge n makes the entry visible at the FIFO head after edge n, if the FIFO was empty. RES_VALID rises one cycle after the flag.
- Pop: occurs at an edge where RES_VALID=1 and RES_READY=1; the head advances to the next entry.
- RES_READY while RES_VALID=0: ignored.
- RES_DATA/RES_SRC are stable while RES_VALID=1 and RES_READY=0. When empty, they hold the last popped value.
- Full (FIFO_CNT=DEPTH) and push with no pop in the same cycle: the entry is dropped, OVF_ERR set to 1, and contents are unchanged.
- Full and push with pop in the same cycle: both occur, no drop, FIFO_CNT stays DEPTH.
- Push and pop in the same cycle at any other occupancy: FIFO_CNT is unchanged.
- Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0. FIFO_CNT is tracked separately.
- ERR_CLR=1: both sticky bits are 0 after the edge.
- ERR_CLR and a new error event in the same cycle: the error wins, and the bit reads 1.
- Reset mid-operation: all buffered entries are discarded immediately; outputs go to their reset values without waiting for a clock.

Optional Feature:
- Macro: ALU_COLLECT_SEQ_EN.
- Defined:
  - Adds output RES_SEQ [7:0], the sequence tag of the head entry.
  - An 8-bit counter, reset to 0, is stored with each accepted push and then increments.
  - The counter wraps 255 -> 0.
  - Dropped and multi-flag cycles do not increment the counter.
- Undefined: RES_SEQ port, the counter and the tag storage are absent; all other behaviour is identical.

Test Plan:
1. Reset, then Logic_Flag=1 with Logic_OUT=16'hA5A5 for one cycle, RES_READY=0 -> next cycle RES_VALID=1, RES_DATA=32'h0000A5A5, RES_SRC=01, FIFO_CNT=1.
2. Arith_Flag=1 with Arith_OUT=32'hFFFF0001 and RES_READY=1 -> RES_DATA=32'hFFFF0001 and RES_SRC=00 for one cycle, then RES_VALID=0 and FIFO_CNT=0.
3. With RES_READY=0, push 5 CMP results of values 1..5 (DEPTH=4) -> FIFO_CNT=4 and OVF_ERR=1. Drain -> order 1, 2, 3, 4, all with RES_SRC=10.
4. FIFO full, RES_READY=1 and Shift_Flag=1 with value 16'h0008 in the same cycle -> OVF_ERR stays 0, FIFO_CNT stays 4, and 16'h0008 appears last on drain.
5. Logic_Flag=1 and Shift_Flag=1 together -> no push, MULTI_ERR=1. Then ERR_CLR=1 for one cycle -> MULTI_ERR=0.
6. With 3 entries buffered, pulse RST low between clock edges -> RES_VALID, FIFO_CNT, RES_DATA and the errors go to 0 immediately. With ALU_COLLECT_SEQ_EN defined, the first push after reset has RES_SEQ=0.
